// File: rtl/mips_bus_pkg.sv
// Shared types and helpers for the CPU bus master: access sizes, response
// error codes, FSM states, and byteenable/misalignment decoding from
// access size plus the byte offset within the word.
package mips_bus_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_TIMEOUT  = 2'd2
  } err_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BUS,
    S_RDATA,
    S_RESP,
    S_ERR
  } state_t;

  // Lane enables for an aligned access; illegal size yields no lanes.
  function automatic logic [3:0] be_from(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SZ_BYTE: be_from = 4'b0001 << offset;
      SZ_HALF: be_from = 4'b0011 << offset;
      SZ_WORD: be_from = 4'b1111;
      default: be_from = 4'b0000;
    endcase
  endfunction

  // Size 3 has no legal encoding, so it is reported as misaligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = offset[0];
      SZ_WORD: is_misaligned = (offset != 2'd0);
      default: is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mips_bus_lane_align.sv
// Lane alignment datapath for the bus master (purely combinational).
// Ports: st_size/st_data -> st_lanes (store data replicated across lanes);
//        ld_size/ld_offset/ld_signed/ld_word -> ld_data (extracted, extended load).
module mips_bus_lane_align
  import mips_bus_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [31:0] st_data,
  output logic [31:0] st_lanes,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_offset,
  input  logic        ld_signed,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;

  // Replicating the byte/half into every lane puts it in the addressed lane
  // whatever the offset; byteenable selects which lanes actually land.
  always_comb begin
    st_lanes = st_data;
    case (st_size)
      SZ_BYTE: st_lanes = {4{st_data[7:0]}};
      SZ_HALF: st_lanes = {2{st_data[15:0]}};
      default: st_lanes = st_data;
    endcase
  end

  always_comb begin
    shifted = ld_word >> {ld_offset, 3'b000};
    ld_data = ld_word;
    case (ld_size)
      SZ_BYTE: ld_data = {{24{ld_signed & shifted[7]}}, shifted[7:0]};
      SZ_HALF: ld_data = {{16{ld_signed & shifted[15]}}, shifted[15:0]};
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/mips_cpu_bus_master.sv
// Avalon-style bus initiator: one CPU load/store at a time, holds the command
// under waitrequest, returns aligned/extended data or a misalign/timeout error.
// Ports: clk/reset; req_* CPU request; resp_* one-cycle response; address/read/
// write/byteenable/writedata/waitrequest/readdata responder bus.
module mips_cpu_bus_master
  import mips_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned READ_LATENCY   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  // Abort fires on the stalled edge that would bring the count to TIMEOUT_CYCLES.
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT_CYCLES - 1);

  state_t      state, state_n;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic        signed_q;
  logic        write_q;
  err_t        err_q;
  logic [31:0] rword_q;
  logic [CW-1:0] tcount;

  logic [31:0] st_lanes;
  logic [31:0] ld_data;
  logic        req_mis;

  assign req_mis = is_misaligned(req_size, req_addr[1:0]);

  mips_bus_lane_align u_align (
    .st_size   (req_size),
    .st_data   (req_wdata),
    .st_lanes  (st_lanes),
    .ld_size   (size_q),
    .ld_offset (off_q),
    .ld_signed (signed_q),
    .ld_word   (rword_q),
    .ld_data   (ld_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      size_q   <= '0;
      off_q    <= '0;
      signed_q <= 1'b0;
      write_q  <= 1'b0;
      err_q    <= ERR_NONE;
      rword_q  <= '0;
      tcount   <= '0;
    end else begin
      state <= state_n;
      case (state)
        S_IDLE: if (req_valid) begin
          addr_q   <= {req_addr[31:2], 2'b00};
          be_q     <= be_from(req_size, req_addr[1:0]);
          wdata_q  <= st_lanes;
          size_q   <= req_size;
          off_q    <= req_addr[1:0];
          signed_q <= req_signed;
          write_q  <= req_write;
          err_q    <= req_mis ? ERR_MISALIGN : ERR_NONE;
          tcount   <= '0;
        end
        S_BUS: begin
          if (!waitrequest) begin
            if (READ_LATENCY == 0 && !write_q) rword_q <= readdata;
          end else if (tcount == TLAST) begin
            err_q <= ERR_TIMEOUT;
          end else begin
            tcount <= tcount + 1'b1;
          end
        end
        S_RDATA: rword_q <= readdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n    = state;
    req_ready  = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
    resp_valid = 1'b0;
    resp_err   = ERR_NONE;
    resp_rdata = '0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_n = req_mis ? S_ERR : S_BUS;
      end
      S_BUS: begin
        read  = !write_q;
        write = write_q;
        if (!waitrequest)
          state_n = (write_q || READ_LATENCY == 0) ? S_RESP : S_RDATA;
        else if (tcount == TLAST)
          state_n = S_ERR;
      end
      S_RDATA: state_n = S_RESP;
      S_RESP: begin
        resp_valid = 1'b1;
        resp_rdata = write_q ? 32'd0 : ld_data;
        state_n    = S_IDLE;
      end
      S_ERR: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        state_n    = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign address    = addr_q;
  assign byteenable = be_q;
  assign writedata  = wdata_q;

endmodule
